// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types and sizing for the NTT bank scheduler
package ntt_pkg;
    localparam int NTT_DW      = 12;
    localparam int NTT_ADW     = 5;
    localparam int NTT_BFU_LAT = 4;

    localparam int N         = 1 << NTT_ADW;
    localparam int LOG_N     = NTT_ADW;
    localparam int STAGE_LEN = N + NTT_BFU_LAT;
    localparam int STAGE_W   = (LOG_N > 1) ? $clog2(LOG_N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [NTT_ADW-1:0] addr_a;
        logic [NTT_ADW-1:0] addr_b;
    } wb_entry_t;
endpackage

// File: rtl/ntt_bank_sched_if.sv
// rtl/ntt_bank_sched_if.sv - coefficient bank ports and butterfly-unit handshake
interface ntt_bank_sched_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADW        = 5
);
    logic                  ram_we_a_o;
    logic                  ram_we_b_o;
    logic [ADW-1:0]        ram_addr_a_o;
    logic [ADW-1:0]        ram_addr_b_o;
    logic [DATA_WIDTH-1:0] ram_din_a_o;
    logic [DATA_WIDTH-1:0] ram_din_b_o;
    logic                  bf_valid_o;
    logic [ADW-2:0]        tw_idx_o;
    logic [DATA_WIDTH-1:0] bf_x_i;
    logic [DATA_WIDTH-1:0] bf_y_i;

    modport master (
        output ram_we_a_o, ram_we_b_o, ram_addr_a_o, ram_addr_b_o,
        output ram_din_a_o, ram_din_b_o, bf_valid_o, tw_idx_o,
        input  bf_x_i, bf_y_i
    );

    modport slave (
        input  ram_we_a_o, ram_we_b_o, ram_addr_a_o, ram_addr_b_o,
        input  ram_din_a_o, ram_din_b_o, bf_valid_o, tw_idx_o,
        output bf_x_i, bf_y_i
    );
endinterface

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - maps (stage, butterfly) to in-place pair addresses and twiddle
module ntt_addr_gen #(
    parameter int ADW = 5,
    parameter int SW  = 3
) (
    input  logic [SW-1:0]  stage_i,
    input  logic [ADW-2:0] k_i,
    output logic [ADW-1:0] addr_a_o,
    output logic [ADW-1:0] addr_b_o,
    output logic [ADW-2:0] tw_o
);
    int unsigned    shift;
    logic [ADW-1:0] span;
    logic [ADW-1:0] kk;
    logic [ADW-1:0] g;
    logic [ADW-1:0] j;
    logic [ADW-1:0] tw_full;

    // span is a power of two, so divide/modulo reduce to shift/mask
    always_comb begin
        shift    = ADW - 1 - int'(stage_i);
        span     = ADW'(1) << shift;
        kk       = {1'b0, k_i};
        j        = kk & (span - ADW'(1));
        g        = kk >> shift;
        addr_a_o = (g << (shift + 1)) | j;
        addr_b_o = addr_a_o + span;
        tw_full  = j << stage_i;
        tw_o     = tw_full[ADW-2:0];
    end
endmodule

// File: rtl/ntt_bank_sched.sv
// rtl/ntt_bank_sched.sv - in-place NTT sequencer for one dual-port coefficient bank
module ntt_bank_sched
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = NTT_DW,
    parameter int ADW        = NTT_ADW,
    parameter int BFU_LAT    = NTT_BFU_LAT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [STAGE_W-1:0]    stage_o,
    input  logic                  host_we_i,
    input  logic [ADW-1:0]        host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_din_i,
    ntt_bank_sched_if.master      bus
);
    localparam int SLEN  = N + BFU_LAT;
    localparam int CW    = $clog2(SLEN);
    localparam int DEPTH = 1 + BFU_LAT;

    if ((BFU_LAT % 2) != 0) begin : g_lat_chk
        $error("BFU_LAT must be even");
    end
    if (ADW != NTT_ADW) begin : g_adw_chk
        $error("ADW must match ntt_pkg::NTT_ADW");
    end

    state_t                state_q, state_d;
    logic [CW-1:0]         c_q, c_d;
    logic [STAGE_W-1:0]    s_q, s_d;
    logic                  done_q, done_d;
    logic                  vld_q;
    logic [ADW-2:0]        tw_q;
    logic [ADW-1:0]        aa_q, ab_q;
    wb_entry_t             pipe_q [DEPTH];

    logic                  rd;
    wb_entry_t             ent, wb;
    logic                  we_a, we_b;
    logic [ADW-1:0]        addr_a, addr_b;
    logic [DATA_WIDTH-1:0] din_a, din_b;
    logic [ADW-1:0]        gen_a, gen_b;
    logic [ADW-2:0]        gen_tw;

    ntt_addr_gen #(.ADW(ADW), .SW(STAGE_W)) u_addr_gen (
        .stage_i  (s_q),
        .k_i      (c_q[ADW-1:1]),
        .addr_a_o (gen_a),
        .addr_b_o (gen_b),
        .tw_o     (gen_tw)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        s_d     = s_q;
        done_d  = 1'b0;
        we_a    = 1'b0;
        we_b    = 1'b0;
        addr_a  = aa_q;
        addr_b  = ab_q;
        din_a   = '0;
        din_b   = '0;
        rd      = (state_q == RUN) && !c_q[0] && (c_q < CW'(N));
        ent.valid  = rd;
        ent.addr_a = gen_a;
        ent.addr_b = gen_b;
        wb      = pipe_q[DEPTH-1];

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    c_d     = '0;
                    s_d     = '0;
                end
            end
            RUN: begin
                if (c_q == CW'(SLEN - 1)) begin
                    c_d = '0;
                    if (s_q == STAGE_W'(LOG_N - 1)) begin
                        state_d = IDLE;
                        s_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + STAGE_W'(1);
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Reads sit on even c and write-backs on odd c, so they never collide
        if (rst_i) begin
            addr_a = '0;
            addr_b = '0;
        end else if (state_q == IDLE) begin
            we_a   = host_we_i;
            addr_a = host_addr_i;
            addr_b = '0;
            din_a  = host_din_i;
        end else if (rd) begin
            addr_a = gen_a;
            addr_b = gen_b;
        end else if (wb.valid) begin
            we_a   = 1'b1;
            we_b   = 1'b1;
            addr_a = wb.addr_a;
            addr_b = wb.addr_b;
            din_a  = bus.bf_x_i;
            din_b  = bus.bf_y_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            c_q     <= '0;
            s_q     <= '0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            tw_q    <= '0;
            aa_q    <= '0;
            ab_q    <= '0;
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            s_q     <= s_d;
            done_q  <= done_d;
            vld_q   <= rd;
            if (rd) tw_q <= gen_tw;
            if (state_q == RUN) begin
                aa_q <= addr_a;
                ab_q <= addr_b;
            end
            pipe_q[0] <= ent;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign busy_o           = (state_q == RUN);
    assign done_o           = done_q;
    assign stage_o          = s_q;
    assign bus.ram_we_a_o   = we_a;
    assign bus.ram_we_b_o   = we_b;
    assign bus.ram_addr_a_o = addr_a;
    assign bus.ram_addr_b_o = addr_b;
    assign bus.ram_din_a_o  = din_a;
    assign bus.ram_din_b_o  = din_b;
    assign bus.bf_valid_o   = vld_q;
    assign bus.tw_idx_o     = tw_q;
endmodule

// File: tb/tb_ntt_bank_sched.sv
// tb/tb_ntt_bank_sched.sv - scoreboard bench for ntt_bank_sched with bank and swap-butterfly models
module tb_ntt_bank_sched;
    import ntt_pkg::*;

    localparam int DW    = NTT_DW;
    localparam int AW    = NTT_ADW;
    localparam int LAT   = NTT_BFU_LAT;
    localparam int NP    = 1 << AW;
    localparam int LOGN  = AW;
    localparam int SL    = STAGE_LEN;
    localparam int TOTAL = LOGN * SL;
    localparam logic [63:0] DIN_MASK = ~(64'(24'hFFFFFF) << 5);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, host_we;
    logic [AW-1:0]      host_addr;
    logic [DW-1:0]      host_din;
    logic               busy, done;
    logic [STAGE_W-1:0] stage;

    ntt_bank_sched_if #(.DATA_WIDTH(DW), .ADW(AW)) bus ();

    ntt_bank_sched #(.DATA_WIDTH(DW), .ADW(AW), .BFU_LAT(LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .stage_o     (stage),
        .host_we_i   (host_we),
        .host_addr_i (host_addr),
        .host_din_i  (host_din),
        .bus         (bus)
    );

    logic [DW-1:0] mem [NP];
    logic [DW-1:0] dout_a, dout_b;
    always @(posedge clk) begin
        if (bus.ram_we_a_o) mem[bus.ram_addr_a_o] <= bus.ram_din_a_o;
        if (bus.ram_we_b_o) mem[bus.ram_addr_b_o] <= bus.ram_din_b_o;
        dout_a <= mem[bus.ram_addr_a_o];
        dout_b <= mem[bus.ram_addr_b_o];
    end

    // Butterfly stand-in: swaps its operands, LAT cycles late
    logic [DW-1:0] px [LAT];
    logic [DW-1:0] py [LAT];
    always @(posedge clk) begin
        px[0] <= dout_b;
        py[0] <= dout_a;
        for (int i = 1; i < LAT; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end
    assign bus.bf_x_i = px[LAT-1];
    assign bus.bf_y_i = py[LAT-1];

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q [$];
    logic [DW-1:0] mm [NP];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic wa, input logic wb,
                                       input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                                       input logic v, input logic [AW-2:0] tw,
                                       input logic [DW-1:0] da, input logic [DW-1:0] db,
                                       input logic bz, input logic [STAGE_W-1:0] st,
                                       input logic dn);
        return 64'({wa, wb, aa, ab, v, tw, da, db, bz, st, dn});
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle port activity for a full transform, starting from bank image mm
    task automatic push_expected();
        logic [AW-1:0] ra [NP/2];
        logic [AW-1:0] rb [NP/2];
        logic [AW-2:0] tws [NP/2];
        logic [DW-1:0] xa [NP/2];
        logic [DW-1:0] xb [NP/2];
        logic [AW-1:0] la, lb, ea, eb;
        logic [AW-2:0] etw;
        logic [DW-1:0] eda, edb;
        logic ew, ev;
        int span, k;
        la = '0;
        lb = '0;
        for (int s = 0; s < LOGN; s++) begin
            span = NP >> (s + 1);
            for (int g = 0; g < NP / (2 * span); g++) begin
                for (int j = 0; j < span; j++) begin
                    k = g * span + j;
                    ra[k]  = AW'(2 * g * span + j);
                    rb[k]  = AW'(2 * g * span + j + span);
                    tws[k] = (AW-1)'(j << s);
                    xa[k]  = mm[2 * g * span + j + span];
                    xb[k]  = mm[2 * g * span + j];
                end
            end
            for (int c = 0; c < SL; c++) begin
                ew = 1'b0; ev = 1'b0; etw = '0; eda = '0; edb = '0;
                ea = la; eb = lb;
                if ((c % 2 == 0) && (c < NP)) begin
                    ea = ra[c/2];
                    eb = rb[c/2];
                end
                if ((c % 2 == 1) && (c >= 1 + LAT)) begin
                    k = (c - 1 - LAT) / 2;
                    ew = 1'b1; ea = ra[k]; eb = rb[k]; eda = xa[k]; edb = xb[k];
                end
                if ((c % 2 == 1) && (c < NP)) begin
                    ev  = 1'b1;
                    etw = tws[(c-1)/2];
                end
                la = ea;
                lb = eb;
                exp_q.push_back(pk(ew, ew, ea, eb, ev, etw, eda, edb, 1'b1, STAGE_W'(s), 1'b0));
            end
            for (int i = 0; i < NP/2; i++) begin
                mm[ra[i]] = xa[i];
                mm[rb[i]] = xb[i];
            end
        end
    endtask

    // Entered at posedge+1 of cycle 0; leaves at posedge+1 of cycle ncyc
    task automatic run_cycles(input int ncyc, input bit chk_din, input int pulse_at);
        logic [63:0] obs, exp;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            start = (cyc == pulse_at);
            @(negedge clk);
            obs = pk(bus.ram_we_a_o, bus.ram_we_b_o, bus.ram_addr_a_o, bus.ram_addr_b_o,
                     bus.bf_valid_o, bus.bf_valid_o ? bus.tw_idx_o : '0,
                     bus.ram_we_a_o ? bus.ram_din_a_o : '0,
                     bus.ram_we_b_o ? bus.ram_din_b_o : '0, busy, stage, done);
            if (exp_q.size() == 0) begin
                check($sformatf("sb_empty_c%0d", cyc), 64'(exp_q.size()), 64'd1);
            end else begin
                exp = exp_q.pop_front();
                if (!chk_din) begin
                    obs = obs & DIN_MASK;
                    exp = exp & DIN_MASK;
                end
                check($sformatf("run_c%0d", cyc), obs, exp);
            end
            if (cyc == 5)
                check("wb_c5", 64'({bus.ram_we_a_o, bus.ram_we_b_o, bus.ram_addr_a_o, bus.ram_addr_b_o}),
                      64'({1'b1, 1'b1, 5'd0, 5'd16}));
            if (cyc == SL + 18)
                check("map_s1_k9", 64'({bus.ram_addr_a_o, bus.ram_addr_b_o}), 64'({5'd17, 5'd25}));
            if (cyc == SL + 19)
                check("map_s1_k9_tw", 64'(bus.tw_idx_o), 64'd2);
            if (cyc == 4 * SL + 6)
                check("map_s4_k3", 64'({bus.ram_addr_a_o, bus.ram_addr_b_o}), 64'({5'd6, 5'd7}));
            if (cyc == 4 * SL + 7)
                check("map_s4_k3_tw", 64'(bus.tw_idx_o), 64'd0);
            next_cycle();
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        host_we = 1'b1; host_addr = 5'd5; host_din = 12'd7;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            check("reset_state", pk(bus.ram_we_a_o, bus.ram_we_b_o, bus.ram_addr_a_o, bus.ram_addr_b_o,
                                    bus.bf_valid_o, bus.tw_idx_o, '0, '0, busy, stage, done), 64'd0);
        end
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < NP; i++) begin
            host_we = 1'b1; host_addr = AW'(i); host_din = DW'(i);
            mm[i] = DW'(i);
            @(negedge clk);
            check($sformatf("host_wr_%0d", i),
                  64'({bus.ram_we_a_o, bus.ram_addr_a_o, bus.ram_din_a_o, bus.ram_we_b_o, busy}),
                  64'({1'b1, AW'(i), DW'(i), 1'b0, 1'b0}));
            next_cycle();
        end
        host_we = 1'b0;
        for (int i = 0; i < NP; i++) begin
            host_addr = AW'(i);
            next_cycle();
            @(negedge clk);
            check($sformatf("host_rd_%0d", i), 64'({dout_a, bus.ram_we_b_o}), 64'({DW'(i), 1'b0}));
        end

        next_cycle();
        push_expected();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        run_cycles(TOTAL, 1'b1, 20);
        @(negedge clk);
        check("done_pulse", 64'({done, busy, stage}), 64'({1'b1, 1'b0, STAGE_W'(0)}));
        next_cycle();
        @(negedge clk);
        check("done_clear", 64'({done, busy}), 64'd0);

        for (int i = 0; i < NP; i++) begin
            host_addr = AW'(i);
            next_cycle();
            @(negedge clk);
            check($sformatf("final_%0d", i), 64'(dout_a), 64'(NP - 1 - i));
        end

        next_cycle();
        exp_q.delete();
        push_expected();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        run_cycles(50, 1'b1, -1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_gate", 64'({bus.ram_we_a_o, bus.ram_we_b_o, bus.ram_addr_a_o, bus.ram_addr_b_o}), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_next", 64'({busy, done, bus.ram_we_a_o, bus.ram_we_b_o, bus.bf_valid_o, stage}), 64'd0);
        next_cycle();
        @(negedge clk);
        check("rst_no_done", 64'({busy, done}), 64'd0);

        exp_q.delete();
        push_expected();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        run_cycles(8, 1'b0, -1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
